// File: rtl/cl_adder.sv
// ---------------------------------------------------------------------------
// cl_adder : WIDTH-bit carry-lookahead adder (purely combinational).
//
// Carries are resolved in 4-bit groups: each group produces a group
// generate/propagate pair, group carries are chained from those pairs, and
// the carries inside a group are then derived from the group carry-in.
//
// Ports:
//   a    in  WIDTH  addend
//   b    in  WIDTH  addend
//   cin  in  1      carry into bit 0
//   sum  out WIDTH  a + b + cin (low WIDTH bits)
//   cout out 1      carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module cl_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int GROUPS = (WIDTH + 3) / 4;
  localparam int PW     = GROUPS * 4;

  logic [PW-1:0]     a_pad_s;
  logic [PW-1:0]     b_pad_s;
  logic [PW-1:0]     gen_s;
  logic [PW-1:0]     prop_s;
  logic [PW:0]       carry_s;
  logic [GROUPS-1:0] grp_gen_s;
  logic [GROUPS-1:0] grp_prop_s;
  logic [GROUPS:0]   grp_carry_s;
  logic [PW-1:0]     sum_pad_s;

  // Group lookahead carry network and sum formation.
  always_comb begin
    a_pad_s              = {PW{1'b0}};
    b_pad_s              = {PW{1'b0}};
    a_pad_s[WIDTH-1:0]   = a;
    b_pad_s[WIDTH-1:0]   = b;
    gen_s                = a_pad_s & b_pad_s;
    prop_s               = a_pad_s ^ b_pad_s;
    grp_gen_s            = {GROUPS{1'b0}};
    grp_prop_s           = {GROUPS{1'b0}};
    grp_carry_s          = {(GROUPS+1){1'b0}};
    carry_s              = {(PW+1){1'b0}};
    grp_carry_s[0]       = cin;
    for (int k = 0; k < GROUPS; k++) begin
      grp_gen_s[k]  = gen_s[4*k+3]
                    | (prop_s[4*k+3] & gen_s[4*k+2])
                    | (prop_s[4*k+3] & prop_s[4*k+2] & gen_s[4*k+1])
                    | (prop_s[4*k+3] & prop_s[4*k+2] & prop_s[4*k+1] & gen_s[4*k]);
      grp_prop_s[k] = &prop_s[4*k +: 4];
      grp_carry_s[k+1] = grp_gen_s[k] | (grp_prop_s[k] & grp_carry_s[k]);
    end
    for (int k = 0; k < GROUPS; k++) begin
      carry_s[4*k] = grp_carry_s[k];
      for (int i = 0; i < 3; i++) begin
        carry_s[4*k+i+1] = gen_s[4*k+i] | (prop_s[4*k+i] & carry_s[4*k+i]);
      end
    end
    carry_s[PW] = grp_carry_s[GROUPS];
    sum_pad_s   = prop_s ^ carry_s[PW-1:0];
  end

  assign sum  = sum_pad_s[WIDTH-1:0];
  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/booth_mult_unit.sv
// ---------------------------------------------------------------------------
// booth_mult_unit : iterative radix-2 Booth signed multiplier.
//
// One Booth step per clock. The WIDTH-bit part of each accumulator update
// goes through a single cl_adder; the extra accumulator sign bit is formed
// from the operand sign bits and the adder carry out. After WIDTH steps the
// low product half and an overflow flag are registered and a one-cycle ready
// pulse is issued.
//
// Optional feature macro: BOOTH_MULT_EARLY_TERM_EN
//   When defined, a zero operand at the start edge skips the iterations and
//   goes straight to DONE with a zero result.
//
// Ports:
//   clk             in  1      rising-edge clock
//   reset_n         in  1      asynchronous active-low reset
//   ctrl_MULT       in  1      start pulse, operands sampled on the same edge
//   data_operandA   in  WIDTH  multiplicand (two's complement)
//   data_operandB   in  WIDTH  multiplier (two's complement)
//   data_result     out WIDTH  low WIDTH bits of the product
//   data_exception  out 1      product does not fit in signed WIDTH bits
//   data_resultRDY  out 1      one-cycle result-valid pulse
//   busy            out 1      high while iterating
// ---------------------------------------------------------------------------
module booth_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // High when the bits of v are not all identical (upper product half plus
  // the sign bit of the lower half disagree -> result overflowed).
  function automatic logic not_all_equal(input logic [WIDTH:0] v);
    return !((&v) || (~|v));
  endfunction

  state_t           state_r, state_nx;
  logic [CW-1:0]    cnt_r, cnt_nx;
  logic [WIDTH:0]   acc_r, acc_nx;
  logic [WIDTH-1:0] q_r, q_nx;
  logic             q1_r, q1_nx;
  logic [WIDTH:0]   m_r, m_nx;
  logic [WIDTH-1:0] result_r, result_nx;
  logic             exc_r, exc_nx;
  logic             rdy_r, rdy_nx;
  logic             busy_r, busy_nx;

  logic [WIDTH:0]   add_b_s;
  logic             add_cin_s;
  logic [WIDTH-1:0] add_sum_s;
  logic             add_cout_s;
  logic [WIDTH:0]   acc_sum_s;
  logic [WIDTH:0]   acc_sh_s;
  logic [WIDTH-1:0] q_sh_s;
  logic             q1_sh_s;

  // Booth recoding: pick +M, -M (as ~M with carry-in) or nothing.
  always_comb begin
    add_b_s   = {(WIDTH+1){1'b0}};
    add_cin_s = 1'b0;
    case ({q_r[0], q1_r})
      2'b01: begin
        add_b_s   = m_r;
        add_cin_s = 1'b0;
      end
      2'b10: begin
        add_b_s   = ~m_r;
        add_cin_s = 1'b1;
      end
      default: begin
        add_b_s   = {(WIDTH+1){1'b0}};
        add_cin_s = 1'b0;
      end
    endcase
  end

  cl_adder #(
    .WIDTH (WIDTH)
  ) u_cl_adder (
    .a    (acc_r[WIDTH-1:0]),
    .b    (add_b_s[WIDTH-1:0]),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Top accumulator bit: sum bit WIDTH = a ^ b ^ carry-in to that bit.
  assign acc_sum_s = {acc_r[WIDTH] ^ add_b_s[WIDTH] ^ add_cout_s, add_sum_s};

  // Arithmetic shift right of the whole {ACC, Q, q_1} register by one.
  assign acc_sh_s = {acc_sum_s[WIDTH], acc_sum_s[WIDTH:1]};
  assign q_sh_s   = {acc_sum_s[0], q_r[WIDTH-1:1]};
  assign q1_sh_s  = q_r[0];

  // Next-state and datapath update; a start request always wins over the
  // current state, which gives abort-and-restart in RUN and back-to-back
  // starts from DONE.
  always_comb begin
    state_nx  = state_r;
    cnt_nx    = cnt_r;
    acc_nx    = acc_r;
    q_nx      = q_r;
    q1_nx     = q1_r;
    m_nx      = m_r;
    result_nx = result_r;
    exc_nx    = exc_r;
    rdy_nx    = 1'b0;
    busy_nx   = busy_r;
    if (ctrl_MULT) begin
      acc_nx   = {(WIDTH+1){1'b0}};
      q_nx     = data_operandB;
      q1_nx    = 1'b0;
      m_nx     = {data_operandA[WIDTH-1], data_operandA};
      cnt_nx   = {CW{1'b0}};
      state_nx = S_RUN;
      busy_nx  = 1'b1;
`ifdef BOOTH_MULT_EARLY_TERM_EN
      if ((data_operandA == {WIDTH{1'b0}}) || (data_operandB == {WIDTH{1'b0}})) begin
        state_nx  = S_DONE;
        busy_nx   = 1'b0;
        result_nx = {WIDTH{1'b0}};
        exc_nx    = 1'b0;
        rdy_nx    = 1'b1;
      end else begin
        state_nx  = S_RUN;
      end
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          busy_nx = 1'b0;
        end
        S_RUN: begin
          acc_nx = acc_sh_s;
          q_nx   = q_sh_s;
          q1_nx  = q1_sh_s;
          cnt_nx = cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            state_nx  = S_DONE;
            busy_nx   = 1'b0;
            result_nx = q_sh_s;
            exc_nx    = not_all_equal({acc_sh_s[WIDTH-1:0], q_sh_s[WIDTH-1]});
            rdy_nx    = 1'b1;
          end else begin
            state_nx  = S_RUN;
          end
        end
        S_DONE: begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
        end
        default: begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(WIDTH+1){1'b0}};
      q_r      <= {WIDTH{1'b0}};
      q1_r     <= 1'b0;
      m_r      <= {(WIDTH+1){1'b0}};
      result_r <= {WIDTH{1'b0}};
      exc_r    <= 1'b0;
      rdy_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      acc_r    <= acc_nx;
      q_r      <= q_nx;
      q1_r     <= q1_nx;
      m_r      <= m_nx;
      result_r <= result_nx;
      exc_r    <= exc_nx;
      rdy_r    <= rdy_nx;
      busy_r   <= busy_nx;
    end
  end

  assign data_result    = result_r;
  assign data_exception = exc_r;
  assign data_resultRDY = rdy_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_booth_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_unit : directed self-checking bench for booth_mult_unit.
// Expected products are hand-computed constants; latency is counted in
// clock edges after the start edge, sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_booth_mult_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive operands with a start request; returns just after the start edge.
  task automatic start_op(input logic [31:0] opa, input logic [31:0] opb);
    @(negedge clk);
    data_operandA = opa;
    data_operandB = opb;
    ctrl_MULT     = 1'b1;
    @(posedge clk);
  endtask

  // Releases the start request and counts edges until the ready pulse.
  task automatic wait_ready(output int lat, output int busy_cnt);
    lat      = 999;
    busy_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) ctrl_MULT = 1'b0;
      if (data_resultRDY) begin
        lat = k;
        break;
      end
      busy_cnt += int'(busy);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                        input int exp_lat, input int exp_busy,
                        input logic [31:0] exp_res, input logic exp_exc);
    int lat;
    int bc;
    start_op(opa, opb);
    wait_ready(lat, bc);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(bc), 32'(exp_busy));
    chk({tag, " result"}, data_result, exp_res);
    chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
    @(negedge clk);
    chk({tag, " rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
    chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int bc;
    int rdy_cnt;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst result", data_result, 32'd0);
    chk("rst exception", {31'd0, data_exception}, 32'd0);
    chk("rst rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    run_op("3x5",      32'd3,          32'd5,          32, 32, 32'h0000000F, 1'b0);
    run_op("m7x6",     32'hFFFFFFF9,   32'd6,          32, 32, 32'hFFFFFFD6, 1'b0);
    run_op("2p16sq",   32'h00010000,   32'h00010000,   32, 32, 32'h00000000, 1'b1);
    run_op("minxm1",   32'h80000000,   32'hFFFFFFFF,   32, 32, 32'h80000000, 1'b1);
    run_op("minx1",    32'h80000000,   32'd1,          32, 32, 32'h80000000, 1'b0);
`ifdef BOOTH_MULT_EARLY_TERM_EN
    run_op("zeroA",    32'd0,          32'h00001234,   0,  0,  32'h00000000, 1'b0);
`else
    run_op("zeroA",    32'd0,          32'h00001234,   32, 32, 32'h00000000, 1'b0);
`endif

    // Abort: start 3*5, restart with 4*4 on the tenth edge after the start.
    start_op(32'd3, 32'd5);
    rdy_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) ctrl_MULT = 1'b0;
      rdy_cnt += int'(data_resultRDY);
    end
    @(negedge clk);
    rdy_cnt += int'(data_resultRDY);
    data_operandA = 32'd4;
    data_operandB = 32'd4;
    ctrl_MULT     = 1'b1;
    @(posedge clk);
    chk("abort early_rdy", 32'(rdy_cnt), 32'd0);
    wait_ready(lat, bc);
    chk("abort latency", 32'(lat), 32'd32);
    chk("abort result", data_result, 32'h00000010);
    chk("abort exception", {31'd0, data_exception}, 32'd0);
    rdy_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rdy_cnt += int'(data_resultRDY);
    end
    chk("abort extra_rdy", 32'(rdy_cnt), 32'd0);

    // Start held high: every edge restarts, so no ready pulse appears.
    @(negedge clk);
    data_operandA = 32'd2;
    data_operandB = 32'd2;
    ctrl_MULT     = 1'b1;
    rdy_cnt       = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rdy_cnt += int'(data_resultRDY);
    end
    chk("held rdy", 32'(rdy_cnt), 32'd0);
    chk("held busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    wait_ready(lat, bc);
    chk("held latency", 32'(lat), 32'd32);
    chk("held result", data_result, 32'h00000004);

    // Reset mid-operation, after a result with exception set is held.
    run_op("prerst", 32'h80000000, 32'hFFFFFFFF, 32, 32, 32'h80000000, 1'b1);
    start_op(32'd7, 32'd9);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) ctrl_MULT = 1'b0;
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst result", data_result, 32'd0);
    chk("midrst exception", {31'd0, data_exception}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rdy_cnt = 0;
    bc      = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rdy_cnt += int'(data_resultRDY);
      bc      += int'(busy);
    end
    chk("postrst rdy", 32'(rdy_cnt), 32'd0);
    chk("postrst busy", 32'(bc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
